if_stage: RTL

Instruction fetch stage of the 5-stage ARM pipeline: the producer end of the IF/ID interface that the decode stage consumes. It owns the PC and issues requests on a variable-latency instruction-memory handshake. It absorbs freezes from the hazard unit without losing a returned word and redirects on taken branches from EXE. It delivers the `{PC+4, instruction, valid}` IF/ID pipeline register into the ID stage.

---
 rtl/if_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory handshake and the IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_stall event counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // A request in flight is never withdrawn: DROP keeps presenting the abandoned address.
    assign imem_req  = rst && (state_q != S_HOLD);
    assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

    assign pc_out      = pc_out_q;
    assign instruction = instr_q;
    assign valid       = valid_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        hold_buf_d  = hold_buf_q;
        hold_pc_d   = hold_pc_q;
        drop_addr_d = drop_addr_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;

        if (branch_taken) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
            pc_d    = {branch_addr[31:2], 2'b00};
            case (state_q)
                S_FETCH: begin
                    if (!imem_ready) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end
                S_HOLD:  state_d = S_FETCH;
                default: state_d = S_DROP;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready && !freeze) begin
                        pc_out_d = pc_plus4;
                        instr_d  = imem_rdata;
                        valid_d  = 1'b1;
                        pc_d     = pc_plus4;
                    end else if (imem_ready) begin
                        hold_buf_d = imem_rdata;
                        hold_pc_d  = pc_plus4;
                        pc_d       = pc_plus4;
                        state_d    = S_HOLD;
                    end else if (!freeze) begin
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        pc_out_d = hold_pc_q;
                        instr_d  = hold_buf_q;
                        valid_d  = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
                default: begin
                    instr_d = 32'h0;
                    valid_d = 1'b0;
                    if (imem_ready) state_d = S_FETCH;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            hold_buf_q  <= 32'h0;
            hold_pc_q   <= 32'h0;
            drop_addr_q <= 32'h0;
            pc_out_q    <= 32'h0;
            instr_q     <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_buf_q  <= hold_buf_d;
            hold_pc_q   <= hold_pc_d;
            drop_addr_q <= drop_addr_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        fetched_inc, stall_inc;

    always_comb begin
        fetched_inc = !branch_taken && !freeze &&
                      (((state_q == S_FETCH) && imem_ready) || (state_q == S_HOLD));
        stall_inc   = freeze || ((state_q == S_FETCH) && !imem_ready);
        perf_fetched_d = perf_fetched_q + {31'h0, fetched_inc};
        perf_stall_d   = perf_stall_q + {31'h0, stall_inc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= 32'h0;
            perf_stall_q   <= 32'h0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
